// File: rtl/elevator_scan_ctrl_pkg.sv
// Shared types for the SCAN elevator controller: state codes, travel direction,
// and the registered output bundle with its Moore decode.
package elevator_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DOOR_OPEN = 3'd1,
        ST_MOVE_UP   = 3'd2,
        ST_MOVE_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    typedef struct packed {
        logic door_open;
        logic moving;
        logic up;
        logic down;
        logic error;
    } ctrl_out_t;

    // Moore output pattern for a given state; unknown codes give all zeros
    function automatic ctrl_out_t state_outputs(state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            ST_DOOR_OPEN: o.door_open = 1'b1;
            ST_MOVE_UP:   begin o.moving = 1'b1; o.up   = 1'b1; end
            ST_MOVE_DOWN: begin o.moving = 1'b1; o.down = 1'b1; end
            ST_FAULT:     o.error = 1'b1;
            default:      o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/elevator_scan_ctrl_req_scan.sv
// Latched call register plus here/above/below reductions against a probe floor.
module elevator_scan_ctrl_req_scan
    import elevator_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  clr_en,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic [FLOOR_W-1:0]    ref_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  any_here_c,
    output logic                  any_above_c,
    output logic                  any_below_c
);

    logic [NUM_FLOORS-1:0] clr_mask;

    // Service clear for the floor the door is open at; it beats a same-cycle call
    always_comb begin
        clr_mask = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (clr_en && (FLOOR_W'(i) == cur_floor)) begin
                clr_mask[i] = 1'b1;
            end
        end
    end

    // Reduce pending calls relative to the probe floor
    always_comb begin
        any_here_c  = 1'b0;
        any_above_c = 1'b0;
        any_below_c = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i]) begin
                if (FLOOR_W'(i) == ref_floor) any_here_c  = 1'b1;
                if (FLOOR_W'(i) >  ref_floor) any_above_c = 1'b1;
                if (FLOOR_W'(i) <  ref_floor) any_below_c = 1'b1;
            end
        end
    end

    // Call latch: set by call_req, cleared when served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending | call_req) & ~clr_mask;
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: call scheduling, floor travel and door dwell timing,
// emergency stop handling. Outputs are registered decodes of the next state.
module elevator_scan_ctrl
    import elevator_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = 8,
    parameter int unsigned FLOOR_W       = 3,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  door_hold,
    input  logic                  close_req,
    input  logic                  estop,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  moving,
    output logic                  up,
    output logic                  down,
    output logic                  error
);

    localparam int unsigned TRAV_W  = $clog2(TRAVEL_CYCLES + 1);
    localparam int unsigned DWELL_W = $clog2(DOOR_CYCLES + 1);
    localparam logic [TRAV_W-1:0]  TRAV_LOAD = TRAV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DOOR_LOAD = DWELL_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    state_t               state, state_nxt;
    dir_t                 last_dir, dir_nxt;
    logic [TRAV_W-1:0]    trav, trav_nxt;
    logic [DWELL_W-1:0]   dwell, dwell_nxt;
    logic [FLOOR_W-1:0]   floor_q, floor_nxt, ref_floor;
    ctrl_out_t            outs_q, outs_nxt;
    logic                 any_here, any_above, any_below;

    elevator_scan_ctrl_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_req_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .call_req    (call_req),
        .clr_en      (state == ST_DOOR_OPEN),
        .cur_floor   (floor_q),
        .ref_floor   (ref_floor),
        .pending     (pending),
        .any_here_c  (any_here),
        .any_above_c (any_above),
        .any_below_c (any_below)
    );

    // Probe the floor being arrived at so arrival decisions see its calls
    always_comb begin
        ref_floor = floor_q;
        if (trav == '0) begin
            if (state == ST_MOVE_UP && floor_q != TOP_FLOOR) begin
                ref_floor = floor_q + FLOOR_W'(1);
            end else if (state == ST_MOVE_DOWN && floor_q != '0) begin
                ref_floor = floor_q - FLOOR_W'(1);
            end
        end
    end

    // State register with travel/dwell counters, floor, direction and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last_dir <= DIR_UP;
            trav     <= '0;
            dwell    <= '0;
            floor_q  <= '0;
            outs_q   <= '0;
        end else begin
            state    <= state_nxt;
            last_dir <= dir_nxt;
            trav     <= trav_nxt;
            dwell    <= dwell_nxt;
            floor_q  <= floor_nxt;
            outs_q   <= outs_nxt;
        end
    end

    // Next-state: estop overrides, then SCAN scheduling and timer handling
    always_comb begin
        state_nxt = state;
        dir_nxt   = last_dir;
        trav_nxt  = trav;
        dwell_nxt = dwell;
        floor_nxt = floor_q;
        if (estop) begin
            state_nxt = ST_FAULT;
            trav_nxt  = '0;
            dwell_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_here) begin
                        state_nxt = ST_DOOR_OPEN;
                        dwell_nxt = DOOR_LOAD;
                    end else if (any_above && any_below) begin
                        state_nxt = (last_dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
                        trav_nxt  = TRAV_LOAD;
                    end else if (any_above) begin
                        state_nxt = ST_MOVE_UP;
                        trav_nxt  = TRAV_LOAD;
                    end else if (any_below) begin
                        state_nxt = ST_MOVE_DOWN;
                        trav_nxt  = TRAV_LOAD;
                    end
                end
                ST_DOOR_OPEN: begin
                    if (door_hold) begin
                        dwell_nxt = DOOR_LOAD;
                    end else if (close_req || dwell == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        dwell_nxt = dwell - DWELL_W'(1);
                    end
                end
                ST_MOVE_UP: begin
                    if (floor_q == TOP_FLOOR) begin
                        state_nxt = ST_IDLE;
                    end else if (trav == '0) begin
                        floor_nxt = ref_floor;
                        dir_nxt   = DIR_UP;
                        if (any_here) begin
                            state_nxt = ST_DOOR_OPEN;
                            dwell_nxt = DOOR_LOAD;
                        end else if (any_above) begin
                            trav_nxt  = TRAV_LOAD;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        trav_nxt = trav - TRAV_W'(1);
                    end
                end
                ST_MOVE_DOWN: begin
                    if (floor_q == '0) begin
                        state_nxt = ST_IDLE;
                    end else if (trav == '0) begin
                        floor_nxt = ref_floor;
                        dir_nxt   = DIR_DOWN;
                        if (any_here) begin
                            state_nxt = ST_DOOR_OPEN;
                            dwell_nxt = DOOR_LOAD;
                        end else if (any_below) begin
                            trav_nxt  = TRAV_LOAD;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        trav_nxt = trav - TRAV_W'(1);
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_FAULT;
                    trav_nxt  = '0;
                    dwell_nxt = '0;
                end
            endcase
        end
    end

    // Output decode of the next state, captured at the same edge
    always_comb begin
        outs_nxt = state_outputs(state_nxt);
    end

    assign cur_floor = floor_q;
    assign door_open = outs_q.door_open;
    assign moving    = outs_q.moving;
    assign up        = outs_q.up;
    assign down      = outs_q.down;
    assign error     = outs_q.error;

endmodule
